// File: rtl/ex_stage.sv
// RV32I execute stage: operand forwarding, ALU, branch resolution and the EX/MEM register.
// Define EX_MUL_EN to build the iterative shift-add multiplier that stalls the front end.
module ex_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_address_in,
  input  logic [31:0] rd1_in,
  input  logic [31:0] rd2_in,
  input  logic [31:0] imm_data_in,
  input  logic [4:0]  rs1_in,
  input  logic [4:0]  rs2_in,
  input  logic [4:0]  rd_in,
  input  logic [2:0]  funct3_in,
  input  logic        funct7_5_in,
  input  logic        funct7_0_in,
  input  logic        branch_in,
  input  logic        memtoreg_in,
  input  logic        memwrite_in,
  input  logic        aluSrc_in,
  input  logic        regwrite_in,
  input  logic [1:0]  aluop_in,
  input  logic [4:0]  wb_rd,
  input  logic        wb_regwrite,
  input  logic [31:0] wb_data,
  output logic [31:0] alu_result_out,
  output logic [31:0] store_data_out,
  output logic [4:0]  rd_out,
  output logic [2:0]  funct3_out,
  output logic        memtoreg_out,
  output logic        memwrite_out,
  output logic        regwrite_out,
  output logic        branch_taken,
  output logic [31:0] branch_target,
  output logic        stall_out
);

  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_BR  = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;
  localparam logic [1:0] ALUOP_I   = 2'b11;

  logic [31:0] fwd_a;
  logic [31:0] fwd_b;
  logic [31:0] op_b;
  logic [31:0] alu_res;
  logic        br_cond;
  logic        mul_stall;
  logic        mul_done;
  logic [31:0] mul_res;
  logic        f7_0_as_add;

  logic [31:0] alu_result_q, alu_result_d;
  logic [31:0] store_data_q, store_data_d;
  logic [4:0]  rd_q, rd_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        memtoreg_q, memtoreg_d;
  logic        memwrite_q, memwrite_d;
  logic        regwrite_q, regwrite_d;

  // MEM-stage result (our own EX/MEM register) beats the older WB value.
  always_comb begin
    fwd_a = rd1_in;
    if (regwrite_q && (rd_q != 5'd0) && (rd_q == rs1_in)) begin
      fwd_a = alu_result_q;
    end else if (wb_regwrite && (wb_rd != 5'd0) && (wb_rd == rs1_in)) begin
      fwd_a = wb_data;
    end
  end

  always_comb begin
    fwd_b = rd2_in;
    if (regwrite_q && (rd_q != 5'd0) && (rd_q == rs2_in)) begin
      fwd_b = alu_result_q;
    end else if (wb_regwrite && (wb_rd != 5'd0) && (wb_rd == rs2_in)) begin
      fwd_b = wb_data;
    end
  end

  assign op_b = aluSrc_in ? imm_data_in : fwd_b;

`ifdef EX_MUL_EN
  assign f7_0_as_add = (aluop_in == ALUOP_R) && funct7_0_in;
`else
  logic unused_funct7_0;
  assign unused_funct7_0 = funct7_0_in;
  assign f7_0_as_add     = 1'b0;
`endif

  always_comb begin
    alu_res = 32'd0;
    unique case (aluop_in)
      ALUOP_ADD: alu_res = fwd_a + op_b;
      ALUOP_BR:  alu_res = fwd_a - fwd_b;
      default: begin
        if (f7_0_as_add) begin
          alu_res = fwd_a + op_b;
        end else begin
          unique case (funct3_in)
            3'b000: alu_res = (aluop_in == ALUOP_R && funct7_5_in) ? (fwd_a - op_b) : (fwd_a + op_b);
            3'b001: alu_res = fwd_a << op_b[4:0];
            3'b010: alu_res = ($signed(fwd_a) < $signed(op_b)) ? 32'd1 : 32'd0;
            3'b011: alu_res = (fwd_a < op_b) ? 32'd1 : 32'd0;
            3'b100: alu_res = fwd_a ^ op_b;
            3'b101: alu_res = funct7_5_in ? 32'($signed(fwd_a) >>> op_b[4:0]) : (fwd_a >> op_b[4:0]);
            3'b110: alu_res = fwd_a | op_b;
            default: alu_res = fwd_a & op_b;
          endcase
        end
      end
    endcase
  end

  always_comb begin
    br_cond = 1'b0;
    unique case (funct3_in)
      3'b000:  br_cond = (fwd_a == fwd_b);
      3'b001:  br_cond = (fwd_a != fwd_b);
      3'b100:  br_cond = ($signed(fwd_a) < $signed(fwd_b));
      3'b101:  br_cond = ($signed(fwd_a) >= $signed(fwd_b));
      3'b110:  br_cond = (fwd_a < fwd_b);
      3'b111:  br_cond = (fwd_a >= fwd_b);
      default: br_cond = 1'b0;
    endcase
  end

  assign branch_target = instr_address_in + imm_data_in;
  assign branch_taken  = branch_in && (aluop_in == ALUOP_BR) && br_cond && !stall_out;
  assign stall_out     = mul_stall;

`ifdef EX_MUL_EN
  // state | meaning
  // IDLE  | no multiply in flight; a MUL here latches operands and stalls
  // BUSY  | one shift-add step per cycle, 32 steps, front end stalled
  // DONE  | product ready; EX/MEM captures it with the MUL's rd/regwrite
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_DONE = 2'b10
  } mul_state_e;

  mul_state_e  state_q, state_d;
  logic [31:0] mcand_q, mcand_d;
  logic [31:0] mplier_q, mplier_d;
  logic [31:0] acc_q, acc_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        is_mul;

  assign is_mul = (aluop_in == ALUOP_R) && funct7_0_in && (funct3_in == 3'b000);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      mcand_q  <= 32'd0;
      mplier_q <= 32'd0;
      acc_q    <= 32'd0;
      cnt_q    <= 5'd0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    mul_stall = 1'b0;
    mul_done  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (is_mul) begin
          mcand_d   = fwd_a;
          mplier_d  = fwd_b;
          acc_d     = 32'd0;
          cnt_d     = 5'd0;
          mul_stall = 1'b1;
          state_d   = S_BUSY;
        end
      end
      S_BUSY: begin
        mul_stall = 1'b1;
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        mul_done = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign mul_res = acc_q;
`else
  assign mul_stall = 1'b0;
  assign mul_done  = 1'b0;
  assign mul_res   = 32'd0;
`endif

  // A stalled cycle inserts a bubble so nothing downstream sees a half-done MUL.
  always_comb begin
    alu_result_d = alu_res;
    store_data_d = fwd_b;
    rd_d         = rd_in;
    funct3_d     = funct3_in;
    memtoreg_d   = memtoreg_in;
    memwrite_d   = memwrite_in;
    regwrite_d   = regwrite_in;
    if (stall_out) begin
      alu_result_d = 32'd0;
      store_data_d = 32'd0;
      rd_d         = 5'd0;
      funct3_d     = 3'd0;
      memtoreg_d   = 1'b0;
      memwrite_d   = 1'b0;
      regwrite_d   = 1'b0;
    end else if (mul_done) begin
      alu_result_d = mul_res;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alu_result_q <= 32'd0;
      store_data_q <= 32'd0;
      rd_q         <= 5'd0;
      funct3_q     <= 3'd0;
      memtoreg_q   <= 1'b0;
      memwrite_q   <= 1'b0;
      regwrite_q   <= 1'b0;
    end else begin
      alu_result_q <= alu_result_d;
      store_data_q <= store_data_d;
      rd_q         <= rd_d;
      funct3_q     <= funct3_d;
      memtoreg_q   <= memtoreg_d;
      memwrite_q   <= memwrite_d;
      regwrite_q   <= regwrite_d;
    end
  end

  assign alu_result_out = alu_result_q;
  assign store_data_out = store_data_q;
  assign rd_out         = rd_q;
  assign funct3_out     = funct3_q;
  assign memtoreg_out   = memtoreg_q;
  assign memwrite_out   = memwrite_q;
  assign regwrite_out   = regwrite_q;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: reset, forwarding, branches, ALU ops and the MUL path.
module tb_ex_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr_address_in, rd1_in, rd2_in, imm_data_in;
  logic [4:0]  rs1_in, rs2_in, rd_in;
  logic [2:0]  funct3_in;
  logic        funct7_5_in, funct7_0_in;
  logic        branch_in, memtoreg_in, memwrite_in, aluSrc_in, regwrite_in;
  logic [1:0]  aluop_in;
  logic [4:0]  wb_rd;
  logic        wb_regwrite;
  logic [31:0] wb_data;
  logic [31:0] alu_result_out, store_data_out;
  logic [4:0]  rd_out;
  logic [2:0]  funct3_out;
  logic        memtoreg_out, memwrite_out, regwrite_out;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        stall_out;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ex_stage dut (
    .clk(clk), .reset(reset),
    .instr_address_in(instr_address_in), .rd1_in(rd1_in), .rd2_in(rd2_in),
    .imm_data_in(imm_data_in), .rs1_in(rs1_in), .rs2_in(rs2_in), .rd_in(rd_in),
    .funct3_in(funct3_in), .funct7_5_in(funct7_5_in), .funct7_0_in(funct7_0_in),
    .branch_in(branch_in), .memtoreg_in(memtoreg_in), .memwrite_in(memwrite_in),
    .aluSrc_in(aluSrc_in), .regwrite_in(regwrite_in), .aluop_in(aluop_in),
    .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .wb_data(wb_data),
    .alu_result_out(alu_result_out), .store_data_out(store_data_out),
    .rd_out(rd_out), .funct3_out(funct3_out), .memtoreg_out(memtoreg_out),
    .memwrite_out(memwrite_out), .regwrite_out(regwrite_out),
    .branch_taken(branch_taken), .branch_target(branch_target), .stall_out(stall_out)
  );

  task automatic clear_inputs();
    instr_address_in = 0; rd1_in = 0; rd2_in = 0; imm_data_in = 0;
    rs1_in = 0; rs2_in = 0; rd_in = 0; funct3_in = 0;
    funct7_5_in = 0; funct7_0_in = 0; branch_in = 0; memtoreg_in = 0;
    memwrite_in = 0; aluSrc_in = 0; regwrite_in = 0; aluop_in = 2'b00;
    wb_rd = 0; wb_regwrite = 0; wb_data = 0;
  endtask

  // R-type ALU op with given operands; registers untouched unless forwarding tests set rs.
  task automatic set_rtype(input logic [2:0] f3, input logic f75, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] rd);
    clear_inputs();
    aluop_in = 2'b10; funct3_in = f3; funct7_5_in = f75;
    rd1_in = a; rd2_in = b; rd_in = rd; regwrite_in = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    set_rtype(3'b000, 1'b0, 32'd5, 32'd7, 5'd3);
    rs1_in = 5'd1; rs2_in = 5'd2;
    step();
    checks++; if (alu_result_out !== 32'd0) begin errors++; $display("FAIL rst_alu: got %h expected 0", alu_result_out); end
    checks++; if ({rd_out, regwrite_out, memwrite_out, memtoreg_out} !== 8'd0) begin errors++; $display("FAIL rst_ctrl: got %h expected 0", {rd_out, regwrite_out, memwrite_out, memtoreg_out}); end
    checks++; if (stall_out !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b expected 0", stall_out); end
    @(negedge clk);
    reset = 1'b1;
    step();
    checks++; if (alu_result_out !== 32'd12) begin errors++; $display("FAIL rst_first_alu: got %h expected 0000000c", alu_result_out); end
    checks++; if (rd_out !== 5'd3 || regwrite_out !== 1'b1) begin errors++; $display("FAIL rst_first_ctrl: got rd=%0d rw=%b expected rd=3 rw=1", rd_out, regwrite_out); end
  endtask

  task automatic test_forwarding();
    set_rtype(3'b000, 1'b0, 32'd1, 32'd2, 5'd1);
    step();
    set_rtype(3'b000, 1'b0, 32'd0, 32'd0, 5'd2);
    rs1_in = 5'd1; rs2_in = 5'd1;
    step();
    checks++; if (alu_result_out !== 32'd6) begin errors++; $display("FAIL fwd_mem: got %h expected 00000006", alu_result_out); end
    set_rtype(3'b000, 1'b0, 32'd1, 32'd2, 5'd1);
    step();
    set_rtype(3'b000, 1'b0, 32'd0, 32'd0, 5'd2);
    rs1_in = 5'd1; rs2_in = 5'd1;
    wb_rd = 5'd1; wb_data = 32'd9; wb_regwrite = 1'b1;
    step();
    checks++; if (alu_result_out !== 32'd6) begin errors++; $display("FAIL fwd_mem_prio: got %h expected 00000006", alu_result_out); end
    set_rtype(3'b000, 1'b0, 32'd0, 32'd0, 5'd4);
    rs1_in = 5'd1; rs2_in = 5'd1;
    wb_rd = 5'd1; wb_data = 32'd9; wb_regwrite = 1'b1;
    step();
    checks++; if (alu_result_out !== 32'd18) begin errors++; $display("FAIL fwd_wb: got %h expected 00000012", alu_result_out); end
    checks++; if (store_data_out !== 32'd9) begin errors++; $display("FAIL fwd_store: got %h expected 00000009", store_data_out); end
    set_rtype(3'b000, 1'b0, 32'd10, 32'd20, 5'd0);
    step();
    checks++; if (alu_result_out !== 32'd30 || rd_out !== 5'd0) begin errors++; $display("FAIL x0_write: got %h rd=%0d expected 0000001e rd=0", alu_result_out, rd_out); end
    set_rtype(3'b000, 1'b0, 32'd0, 32'd0, 5'd5);
    wb_rd = 5'd0; wb_data = 32'd9; wb_regwrite = 1'b1;
    step();
    checks++; if (alu_result_out !== 32'd0) begin errors++; $display("FAIL fwd_x0: got %h expected 00000000", alu_result_out); end
  endtask

  task automatic test_branch();
    logic [2:0] f3s [6] = '{3'b100, 3'b110, 3'b000, 3'b001, 3'b101, 3'b111};
    logic       exp [6] = '{1'b1,   1'b0,   1'b0,   1'b1,   1'b0,   1'b1};
    for (int i = 0; i < 6; i++) begin
      clear_inputs();
      aluop_in = 2'b01; branch_in = 1'b1; funct3_in = f3s[i];
      rd1_in = 32'hFFFF_FFFF; rd2_in = 32'd1; rs1_in = 5'd7; rs2_in = 5'd8;
      instr_address_in = 32'h100; imm_data_in = 32'hFFFF_FFF8;
      #1;
      checks++; if (branch_taken !== exp[i]) begin errors++; $display("FAIL br_f3_%0d: got %b expected %b", f3s[i], branch_taken, exp[i]); end
    end
    checks++; if (branch_target !== 32'h0000_00F8) begin errors++; $display("FAIL br_target: got %h expected 000000f8", branch_target); end
    funct3_in = 3'b100; branch_in = 1'b0;
    #1;
    checks++; if (branch_taken !== 1'b0) begin errors++; $display("FAIL br_not_branch: got %b expected 0", branch_taken); end
    step();
  endtask

  task automatic test_alu_ops();
    clear_inputs();
    aluop_in = 2'b11; funct3_in = 3'b101; funct7_5_in = 1'b1; aluSrc_in = 1'b1;
    rd1_in = 32'h8000_0000; imm_data_in = 32'h0000_0404; rd_in = 5'd6; regwrite_in = 1'b1;
    step();
    checks++; if (alu_result_out !== 32'hF800_0000) begin errors++; $display("FAIL srai: got %h expected f8000000", alu_result_out); end
    set_rtype(3'b101, 1'b0, 32'h8000_0000, 32'd36, 5'd6);
    step();
    checks++; if (alu_result_out !== 32'h0800_0000) begin errors++; $display("FAIL srl36: got %h expected 08000000", alu_result_out); end
    set_rtype(3'b010, 1'b0, 32'hFFFF_FFFF, 32'd1, 5'd6);
    step();
    checks++; if (alu_result_out !== 32'd1) begin errors++; $display("FAIL slt: got %h expected 00000001", alu_result_out); end
    set_rtype(3'b011, 1'b0, 32'hFFFF_FFFF, 32'd1, 5'd6);
    step();
    checks++; if (alu_result_out !== 32'd0) begin errors++; $display("FAIL sltu: got %h expected 00000000", alu_result_out); end
    set_rtype(3'b000, 1'b1, 32'd5, 32'd7, 5'd6);
    step();
    checks++; if (alu_result_out !== 32'hFFFF_FFFE) begin errors++; $display("FAIL sub: got %h expected fffffffe", alu_result_out); end
    clear_inputs();
    aluop_in = 2'b11; funct3_in = 3'b000; funct7_5_in = 1'b1; aluSrc_in = 1'b1;
    rd1_in = 32'd5; imm_data_in = 32'd7; rd_in = 5'd6; regwrite_in = 1'b1;
    step();
    checks++; if (alu_result_out !== 32'd12) begin errors++; $display("FAIL addi_f75: got %h expected 0000000c", alu_result_out); end
  endtask

  task automatic set_mul();
    set_rtype(3'b000, 1'b0, 32'hFFFF_FFFF, 32'd3, 5'd9);
    funct7_0_in = 1'b1;
  endtask

`ifdef EX_MUL_EN
  task automatic test_mul();
    int stall_cycles;
    int bubble_bad;
    set_mul();
    #1;
    stall_cycles = 0;
    bubble_bad = 0;
    while (stall_out === 1'b1 && stall_cycles < 40) begin
      stall_cycles++;
      step();
      if (regwrite_out !== 1'b0 || alu_result_out !== 32'd0) bubble_bad++;
    end
    checks++; if (stall_cycles !== 33) begin errors++; $display("FAIL mul_stall_len: got %0d expected 33", stall_cycles); end
    checks++; if (bubble_bad !== 0) begin errors++; $display("FAIL mul_bubble: got %0d bad cycles expected 0", bubble_bad); end
    step();
    checks++; if (alu_result_out !== 32'hFFFF_FFFD || rd_out !== 5'd9 || regwrite_out !== 1'b1) begin errors++; $display("FAIL mul_result: got %h rd=%0d expected fffffffd rd=9", alu_result_out, rd_out); end
    clear_inputs();
    step();
    set_mul();
    for (int i = 0; i < 10; i++) step();
    clear_inputs();
    reset = 1'b0;
    #1;
    checks++; if (stall_out !== 1'b0) begin errors++; $display("FAIL mul_reset_stall: got %b expected 0", stall_out); end
    @(negedge clk);
    reset = 1'b1;
    step();
    checks++; if (stall_out !== 1'b0) begin errors++; $display("FAIL mul_reset_idle: got %b expected 0", stall_out); end
  endtask
`else
  task automatic test_mul();
    set_mul();
    #1;
    checks++; if (stall_out !== 1'b0) begin errors++; $display("FAIL nomul_stall: got %b expected 0", stall_out); end
    step();
    checks++; if (alu_result_out !== 32'd2) begin errors++; $display("FAIL nomul_result: got %h expected 00000002", alu_result_out); end
    checks++; if (stall_out !== 1'b0) begin errors++; $display("FAIL nomul_stall2: got %b expected 0", stall_out); end
  endtask
`endif

  initial begin
    clear_inputs();
    test_reset();
    test_forwarding();
    test_branch();
    test_alu_ops();
    test_mul();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
